// File: rtl/mux_nx1_pipe_if.sv
// ---------------------------------------------------------------------------
// mux_nx1_pipe_if
// Bundle of the selector's data/handshake signals.
//
// Signals:
//   in_data   [N*WIDTH] : channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  [N]       : per-channel data-valid
//   in_ready  [N]       : per-channel accept strobe (one-hot or zero)
//   sel       [SEL_W]   : channel select used in fixed mode
//   mode                : 0 = fixed select, 1 = round-robin scan
//   out_data  [WIDTH]   : registered selected word
//   out_ch    [SEL_W]   : registered source channel index
//   out_valid           : out_data/out_ch hold an unconsumed word
//   out_ready           : downstream accept
//   sel_err             : 1-cycle pulse, fixed mode with sel >= N
//   out_par             : even parity of out_data
//                         (present only with MUX_PIPE_PARITY_EN)
//
// Modports:
//   master : the host side (drives the inputs, consumes the outputs)
//   slave  : the selector itself
// ---------------------------------------------------------------------------
interface mux_nx1_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) ();

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_ch;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;
`ifdef MUX_PIPE_PARITY_EN
  logic               out_par;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_ch, out_valid, sel_err, out_par
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err, out_par
  );
`else
  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_ch, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err
  );
`endif

endinterface

// File: rtl/mux_nx1_pipe.sv
// ---------------------------------------------------------------------------
// mux_nx1_pipe
// N-to-1 data selector with a single registered output stage and a
// valid/ready handshake. Fixed mode takes the channel from sel; scan mode
// round-robins over the channels presenting valid data. Every captured word
// is tagged with the index of the channel it came from.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_nx1_pipe_if.slave (in_data/in_valid/in_ready, sel, mode,
//           out_data/out_ch/out_valid/out_ready, sel_err[, out_par])
//
// Optional feature: define MUX_PIPE_PARITY_EN to add out_par, the even
// parity of the captured word, registered alongside out_data.
// ---------------------------------------------------------------------------
module mux_nx1_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_nx1_pipe_if.slave  bus
);

  // Channel space padded to the full select range so that indexing with any
  // sel/grant value stays in bounds; the padding channels are never valid.
  localparam int              PAD_N   = 1 << SEL_W;
  localparam logic [SEL_W:0]  N_EXT   = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  logic [WIDTH-1:0] ch_data [PAD_N];
  logic [PAD_N-1:0] valid_pad;

  assign valid_pad = PAD_N'(bus.in_valid);

  for (genvar gi = 0; gi < PAD_N; gi++) begin : g_ch
    if (gi < N) begin : g_real
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_data[gi] = '0;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [SEL_W-1:0] ptr_reg,       ptr_next;
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic [SEL_W-1:0] out_ch_reg,    out_ch_next;
  logic             out_valid_reg, out_valid_next;
  logic             sel_err_reg,   sel_err_next;
`ifdef MUX_PIPE_PARITY_EN
  logic             out_par_reg,   out_par_next;
`endif

  // -------------------------------------------------------------------------
  // Grant logic
  // -------------------------------------------------------------------------
  logic             load;
  logic             sel_ok;
  logic             scan_hit;
  logic [SEL_W-1:0] scan_idx;
  logic [SEL_W:0]   cand;
  logic             grant;
  logic [SEL_W-1:0] grant_idx;

  // The output register can take a new word when it is empty or its word is
  // being consumed in this same cycle.
  assign load   = !out_valid_reg || bus.out_ready;
  assign sel_ok = {1'b0, bus.sel} < N_EXT;

  // Round-robin search starting at ptr. Walking offsets from the far end
  // down to 0 lets the nearest valid channel overwrite any farther hit.
  // cand never exceeds 2N-2, so one conditional subtract wraps it.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_reg} + (SEL_W + 1)'(i);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (valid_pad[cand[SEL_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (bus.mode) begin
      grant     = load && scan_hit;
      grant_idx = scan_idx;
    end else begin
      grant     = load && sel_ok && valid_pad[bus.sel];
      grant_idx = bus.sel;
    end
  end

  // Accept strobe is held low throughout reset.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign bus.in_ready[gi] = rst_n && grant && (grant_idx == SEL_W'(gi));
  end

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    ptr_next       = ptr_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    out_valid_next = out_valid_reg;
    sel_err_next   = !bus.mode && !sel_ok;
`ifdef MUX_PIPE_PARITY_EN
    out_par_next   = out_par_reg;
`endif

    // The scan pointer only advances on scan-mode grants; fixed mode leaves
    // it untouched so scanning resumes where it left off.
    if (bus.mode && grant) begin
      ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);
    end

    if (grant) begin
      out_data_next  = ch_data[grant_idx];
      out_ch_next    = grant_idx;
      out_valid_next = 1'b1;
`ifdef MUX_PIPE_PARITY_EN
      out_par_next   = ^ch_data[grant_idx];
`endif
    end else if (bus.out_ready) begin
      // Drain: data and channel tag keep their last value.
      out_valid_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      sel_err_reg   <= 1'b0;
`ifdef MUX_PIPE_PARITY_EN
      out_par_reg   <= 1'b0;
`endif
    end else begin
      ptr_reg       <= ptr_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      out_valid_reg <= out_valid_next;
      sel_err_reg   <= sel_err_next;
`ifdef MUX_PIPE_PARITY_EN
      out_par_reg   <= out_par_next;
`endif
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sel_err   = sel_err_reg;
`ifdef MUX_PIPE_PARITY_EN
  assign bus.out_par   = out_par_reg;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_pipe
// Directed bench for mux_nx1_pipe: a WIDTH=8/N=4 instance for the main
// function and a WIDTH=8/N=3 instance for the out-of-range select case.
// Inputs change on the falling edge; in_ready is sampled 1 time unit later,
// registered outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mux_nx1_pipe;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  mux_nx1_pipe_if #(.WIDTH(8), .N(4), .SEL_W(2)) bus4 ();
  mux_nx1_pipe_if #(.WIDTH(8), .N(3), .SEL_W(2)) bus3 ();

  mux_nx1_pipe #(.WIDTH(8), .N(4), .SEL_W(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux_nx1_pipe #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, obs);
    end
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    rst_n          = 1'b0;
    bus4.in_data   = '0;
    bus4.in_valid  = 4'hF;
    bus4.sel       = 2'd0;
    bus4.mode      = 1'b0;
    bus4.out_ready = 1'b1;
    bus3.in_data   = '0;
    bus3.in_valid  = '0;
    bus3.sel       = 2'd0;
    bus3.mode      = 1'b0;
    bus3.out_ready = 1'b1;

    // ---------------- reset state ----------------
    #3;
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_out_data",  32'(bus4.out_data),  32'd0);
    check("rst_out_ch",    32'(bus4.out_ch),    32'd0);
    check("rst_sel_err",   32'(bus4.sel_err),   32'd0);
    check("rst_in_ready",  32'(bus4.in_ready),  32'd0);
`ifdef MUX_PIPE_PARITY_EN
    check("rst_out_par",   32'(bus4.out_par),   32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- 1. fixed select walk ----------------
    bus4.in_data = 32'h4433_2211;
    for (int s = 0; s < 4; s++) begin
      bus4.sel = 2'(s);
      #1;
      check("t1_in_ready", 32'(bus4.in_ready), 32'(1 << s));
      @(posedge clk); #1;
      check("t1_out_data",  32'(bus4.out_data),  32'h11 * (s + 1));
      check("t1_out_ch",    32'(bus4.out_ch),    32'(s));
      check("t1_out_valid", 32'(bus4.out_valid), 32'd1);
      $display("txn fixed sel=%0d data=%02h ch=%0d", s, bus4.out_data, bus4.out_ch);
      @(negedge clk);
    end

    // ---------------- 2. backpressure ----------------
    bus4.sel = 2'd2;
    @(posedge clk); #1;
    check("t2_capture", 32'(bus4.out_data), 32'h33);
`ifdef MUX_PIPE_PARITY_EN
    check("t2_par_33", 32'(bus4.out_par), 32'd0);
`endif
    @(negedge clk);
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t2_stall_in_ready", 32'(bus4.in_ready), 32'd0);
      @(posedge clk); #1;
      check("t2_stall_data",  32'(bus4.out_data),  32'h33);
      check("t2_stall_ch",    32'(bus4.out_ch),    32'd2);
      check("t2_stall_valid", 32'(bus4.out_valid), 32'd1);
      @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    bus4.sel       = 2'd1;
    #1;
    check("t2_release_in_ready", 32'(bus4.in_ready), 32'b0010);
    @(posedge clk); #1;
    check("t2_next_data",  32'(bus4.out_data),  32'h22);
    check("t2_next_ch",    32'(bus4.out_ch),    32'd1);
    check("t2_next_valid", 32'(bus4.out_valid), 32'd1);
    @(negedge clk);

    // drain with nothing valid: word consumed, data/channel hold
    bus4.in_valid = 4'b0000;
    #1;
    check("drain_in_ready", 32'(bus4.in_ready), 32'd0);
    @(posedge clk); #1;
    check("drain_valid", 32'(bus4.out_valid), 32'd0);
    check("drain_data",  32'(bus4.out_data),  32'h22);
    check("drain_ch",    32'(bus4.out_ch),    32'd1);
    @(negedge clk);

    // ---------------- 3. round-robin fairness ----------------
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t3_in_ready", 32'(bus4.in_ready), 32'(1 << rr_seq[i]));
      @(posedge clk); #1;
      check("t3_out_ch",   32'(bus4.out_ch),   32'(rr_seq[i]));
      check("t3_out_data", 32'(bus4.out_data), 32'h11 * (rr_seq[i] + 1));
      $display("txn scan step=%0d ch=%0d data=%02h", i, bus4.out_ch, bus4.out_data);
      @(negedge clk);
    end

    // ---------------- 4. wrap and sparse valid ----------------
    bus4.in_valid = 4'b0100;              // ptr 0 -> grant ch2, ptr becomes 3
    #1;
    check("t4_grant2", 32'(bus4.in_ready), 32'b0100);
    @(posedge clk); #1;
    check("t4_ch2", 32'(bus4.out_ch), 32'd2);
    @(negedge clk);
    bus4.in_valid = 4'b0001;              // from ptr 3 wraps to ch0
    #1;
    check("t4_wrap_grant0", 32'(bus4.in_ready), 32'b0001);
    @(posedge clk); #1;
    check("t4_wrap_ch0",   32'(bus4.out_ch),   32'd0);
    check("t4_wrap_data",  32'(bus4.out_data), 32'h11);
    @(negedge clk);
    bus4.in_valid = 4'b1011;              // ptr now 1 -> ch1 first
    #1;
    check("t4_ptr1", 32'(bus4.in_ready), 32'b0010);
    @(posedge clk); #1;
    @(negedge clk);

    // mode change: fixed grant must not move ptr (ptr stays 2)
    bus4.mode     = 1'b0;
    bus4.sel      = 2'd0;
    bus4.in_valid = 4'hF;
    #1;
    check("mode_fixed_in_ready", 32'(bus4.in_ready), 32'b0001);
    @(posedge clk); #1;
    check("mode_fixed_ch", 32'(bus4.out_ch), 32'd0);
    @(negedge clk);
    bus4.mode = 1'b1;
    #1;
    check("mode_scan_resume", 32'(bus4.in_ready), 32'b0100);
    @(posedge clk); #1;
    check("mode_scan_data", 32'(bus4.out_data), 32'h33);
    @(negedge clk);

    // scan-mode stall: no grant, ptr holds at 3
    bus4.out_ready = 1'b0;
    #1;
    check("scan_stall_in_ready", 32'(bus4.in_ready), 32'd0);
    @(posedge clk); #1;
    check("scan_stall_ch", 32'(bus4.out_ch), 32'd2);
    @(negedge clk);
    bus4.out_ready = 1'b1;
    #1;
    check("scan_after_stall", 32'(bus4.in_ready), 32'b1000);
    @(posedge clk); #1;
    check("scan_after_stall_data", 32'(bus4.out_data), 32'h44);
    @(negedge clk);

    // ---------------- 5. invalid select (N=3) ----------------
    bus3.in_data  = 24'h33_2211;
    bus3.in_valid = 3'b111;
    check("t5_sel_err_idle", 32'(bus3.sel_err), 32'd0);
    bus3.sel = 2'd3;
    #1;
    check("t5_in_ready", 32'(bus3.in_ready), 32'd0);
    @(posedge clk); #1;
    check("t5_sel_err",   32'(bus3.sel_err),   32'd1);
    check("t5_out_valid", 32'(bus3.out_valid), 32'd0);
    @(negedge clk);
    bus3.sel = 2'd0;
    #1;
    check("t5_recover_in_ready", 32'(bus3.in_ready), 32'b001);
    @(posedge clk); #1;
    check("t5_sel_err_clear", 32'(bus3.sel_err),   32'd0);
    check("t5_recover_valid", 32'(bus3.out_valid), 32'd1);
    check("t5_recover_data",  32'(bus3.out_data),  32'h11);
    @(negedge clk);

    // ---------------- 6. async reset mid-transfer ----------------
    // Scan grant to ch0 leaves ptr=1, so a reset of ptr is observable.
    bus4.in_data  = 32'h4433_2207;
    bus4.in_valid = 4'b0001;
    #1;
    check("t6_grant0", 32'(bus4.in_ready), 32'b0001);
    @(posedge clk); #1;
    check("t6_data", 32'(bus4.out_data), 32'h07);
    check("t6_ch",   32'(bus4.out_ch),   32'd0);
`ifdef MUX_PIPE_PARITY_EN
    check("t6_par_07", 32'(bus4.out_par), 32'd1);
`endif
    @(negedge clk);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",    32'(bus4.out_valid), 32'd0);
    check("t6_rst_data",     32'(bus4.out_data),  32'd0);
    check("t6_rst_ch",       32'(bus4.out_ch),    32'd0);
    check("t6_rst_in_ready", 32'(bus4.in_ready),  32'd0);
`ifdef MUX_PIPE_PARITY_EN
    check("t6_rst_par",      32'(bus4.out_par),   32'd0);
`endif
    @(negedge clk);
    rst_n          = 1'b1;
    bus4.out_ready = 1'b1;
    #1;
    check("t6_ptr_reset", 32'(bus4.in_ready), 32'b0001);
    @(posedge clk); #1;
    check("t6_after_rst_data", 32'(bus4.out_data), 32'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
